// File: rtl/inc16.sv
// 16-bit incrementer built as a ripple chain of half adders, with an
// optional registered copy of the result captured under en.
module inc16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        en,
  output logic [15:0] out,
  output logic        cout,
  output logic [15:0] out_q,
  output logic        cout_q,
  output logic        valid_q
);

  logic [16:0] w_c;
  logic [15:0] w_sum;

  logic [15:0] r_out_q;
  logic        r_cout_q;
  logic        r_valid_q;

  // Half-adder chain: the carry into stage 0 is tied high, which is what
  // turns a plain ripple adder into a +1 incrementer.
  always_comb begin
    w_c   = 17'd0;
    w_sum = 16'd0;
    w_c[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      w_sum[i]  = a[i] ^ w_c[i];
      w_c[i+1]  = a[i] & w_c[i];
    end
  end

  assign out  = w_sum;
  assign cout = w_c[16];

  // valid_q is sticky once any capture happens; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_q   <= 16'd0;
      r_cout_q  <= 1'b0;
      r_valid_q <= 1'b0;
    end else if (en) begin
      r_out_q   <= w_sum;
      r_cout_q  <= w_c[16];
      r_valid_q <= 1'b1;
    end
  end

  assign out_q   = r_out_q;
  assign cout_q  = r_cout_q;
  assign valid_q = r_valid_q;

endmodule

// File: tb/tb_inc16.sv
// Directed bench for inc16: combinational increment vectors, registered
// capture/hold behaviour, and synchronous/asynchronous reset effects.
module tb_inc16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic        en;
  logic [15:0] out;
  logic        cout;
  logic [15:0] out_q;
  logic        cout_q;
  logic        valid_q;

  int checks;
  int errors;

  logic [15:0] exp_q[$];

  inc16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .en      (en),
    .out     (out),
    .cout    (cout),
    .out_q   (out_q),
    .cout_q  (cout_q),
    .valid_q (valid_q)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Driver: one clock edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_comb(input logic [15:0] val, input logic [15:0] exp_out, input logic exp_cout);
    a = val;
    #1;
    check16("comb_out", out, exp_out);
    check1("comb_cout", cout, exp_cout);
  endtask

  logic [15:0] vec_a   [8];
  logic [15:0] vec_out [8];
  logic        vec_c   [8];
  logic [15:0] b2b_a   [4];
  logic [15:0] exp_val;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    a      = 16'h0000;

    vec_a[0] = 16'h0000; vec_out[0] = 16'h0001; vec_c[0] = 1'b0;
    vec_a[1] = 16'h0001; vec_out[1] = 16'h0002; vec_c[1] = 1'b0;
    vec_a[2] = 16'hFFFE; vec_out[2] = 16'hFFFF; vec_c[2] = 1'b0;
    vec_a[3] = 16'hFFFF; vec_out[3] = 16'h0000; vec_c[3] = 1'b1;
    vec_a[4] = 16'h00FF; vec_out[4] = 16'h0100; vec_c[4] = 1'b0;
    vec_a[5] = 16'h7FFF; vec_out[5] = 16'h8000; vec_c[5] = 1'b0;
    vec_a[6] = 16'h1234; vec_out[6] = 16'h1235; vec_c[6] = 1'b0;
    vec_a[7] = 16'hA5A5; vec_out[7] = 16'hA5A6; vec_c[7] = 1'b0;

    // Reset state before any clock edge
    #2;
    check16("rst_out_q", out_q, 16'h0000);
    check1("rst_cout_q", cout_q, 1'b0);
    check1("rst_valid_q", valid_q, 1'b0);
    check16("rst_comb_out", out, 16'h0001);

    // Combinational path, exercised while still in reset
    for (int i = 0; i < 8; i++) drive_comb(vec_a[i], vec_out[i], vec_c[i]);

    // A capture requested during reset must be discarded
    en = 1'b1;
    a  = 16'h1234;
    tick();
    check16("rst_hold_out_q", out_q, 16'h0000);
    check1("rst_hold_valid_q", valid_q, 1'b0);

    // Release reset between edges, then capture 00FF
    rst_n = 1'b1;
    a     = 16'h00FF;
    tick();
    check16("cap_out_q", out_q, 16'h0100);
    check1("cap_cout_q", cout_q, 1'b0);
    check1("cap_valid_q", valid_q, 1'b1);

    // en low: registered outputs hold while a moves
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'hFFFF - 16'(i);
      tick();
      check16("hold_out_q", out_q, 16'h0100);
      check1("hold_cout_q", cout_q, 1'b0);
      check1("hold_valid_q", valid_q, 1'b1);
    end

    // Back-to-back captures, one result per edge
    b2b_a[0] = 16'hFFFF;
    b2b_a[1] = 16'hFFFE;
    b2b_a[2] = 16'h0000;
    b2b_a[3] = 16'hFFFF;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = b2b_a[i];
      exp_q.push_back(b2b_a[i] + 16'd1);
      tick();
      exp_val = exp_q.pop_front();
      check16("b2b_out_q", out_q, exp_val);
      check1("b2b_cout_q", cout_q, (b2b_a[i] == 16'hFFFF));
      check1("b2b_valid_q", valid_q, 1'b1);
    end

    // Asynchronous reset between edges clears immediately
    #2;
    rst_n = 1'b0;
    #1;
    check16("async_out_q", out_q, 16'h0000);
    check1("async_cout_q", cout_q, 1'b0);
    check1("async_valid_q", valid_q, 1'b0);
    check16("async_comb_out", out, 16'h0000);
    check1("async_comb_cout", cout, 1'b1);

    // Captures resume on the first edge with reset released and en high
    tick();
    rst_n = 1'b1;
    a     = 16'h0010;
    tick();
    check16("resume_out_q", out_q, 16'h0011);
    check1("resume_cout_q", cout_q, 1'b0);
    check1("resume_valid_q", valid_q, 1'b1);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inc16.md
INC16 -- requirements
Module: inc16

Interface
REQ-001 No parameters; the data width is fixed at 16 bits.
REQ-002 clk  input  1  system clock; all registers rise-edge triggered.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  16  unsigned operand to increment.
REQ-005 en  input  1  capture enable for the registered path.
REQ-006 out  output  16  combinational result, a + 1 modulo 2^16.
REQ-007 cout  output  1  combinational carry-out; high only when a = 16'hFFFF.
REQ-008 out_q  output  16  registered copy of out.
REQ-009 cout_q  output  1  registered copy of cout.
REQ-010 valid_q  output  1  high when out_q and cout_q hold a captured result.

Function
REQ-011 The block SHALL compute out as the low 16 bits of a + 1, with no dependence on clk or rst_n.
REQ-012 The block SHALL build the incrementer as a 16-stage ripple chain of half adders.
- Stage 0 carry-in is constant 1.
- Stage i: sum = a[i] XOR c[i]; c[i+1] = a[i] AND c[i].
- cout = c[16].
REQ-013 out and cout SHALL settle within the same evaluation as any change on a, with no latency.
REQ-014 Wrap-around: a = 16'hFFFF SHALL give out = 16'h0000 and cout = 1.
REQ-015 For every other value of a, cout SHALL be 0.
REQ-016 On each rising clk edge with en = 1 and rst_n = 1, the block SHALL load out_q with out, cout_q with cout, and valid_q with 1.
REQ-017 On each rising clk edge with en = 0, out_q, cout_q and valid_q SHALL hold their values.
REQ-018 The registered path SHALL have a latency of exactly one clock edge after a and en are sampled.
REQ-019 Back-to-back captures with en held high SHALL update out_q every cycle, with no bubbles.
REQ-020 The block SHALL contain no other state: no FSM, and no internal accumulation of out_q back into a.

Reset
REQ-021 While rst_n = 0, out_q SHALL be 16'h0000, cout_q SHALL be 0 and valid_q SHALL be 0, immediately and independent of clk.
REQ-022 Reset SHALL NOT affect the combinational outputs out and cout.
REQ-023 Assertion of rst_n mid-operation SHALL discard any pending capture.
REQ-024 Captures SHALL resume on the first rising clk edge at which rst_n = 1 and en = 1.

Verification
REQ-025 Directed scenario: a = 16'h0000 -> out = 16'h0001, cout = 0.
REQ-026 Directed scenario: a = 16'h0001 -> out = 16'h0002, cout = 0.
REQ-027 Directed scenario: a = 16'hFFFE -> out = 16'hFFFF, cout = 0.
REQ-028 Directed scenario: a = 16'hFFFF -> out = 16'h0000, cout = 1.
REQ-029 Directed scenario: rst_n low, then high, then en = 1 and a = 16'h00FF over one clk edge.
- During reset: out_q = 0, cout_q = 0, valid_q = 0.
- After the edge: out_q = 16'h0100, cout_q = 0, valid_q = 1.
REQ-030 Directed scenario: en = 0 while a changes over several edges -> out_q, cout_q and valid_q unchanged.
- Asynchronous check: rst_n driven low between edges -> out_q = 0 and valid_q = 0 immediately.
